isr_sequencer: RTL and testbench

Sequences entry into and return from the interrupt service routine around the combinational `interrupt_controller`. The block does four things:
- latches interrupt events into a pending register;
- holds the status register `sr` and the exception save registers `esr`, `epc` and `eca`;
- takes an interrupt only at an instruction boundary;
- drives the PC redirect to the ISR start address, or back to `epc` on `eret`.

It sits between the core's commit stage and the fetch PC mux.

---
 rtl/isr_pkg.sv | 24 ++
 rtl/interrupt_controller.sv | 36 +++
 rtl/isr_sequencer.sv | 148 ++++++++++++++
 tb/tb_isr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isr_pkg
// Purpose  : Shared types and constants for the interrupt entry/return
//            sequencer: FSM state encoding, cause-vector width, the
//            non-maskable cause mask and the default ISR start address.
// Revision : 1.0 - initial release
// ============================================================================
package isr_pkg;

    localparam int          NCAUSE    = 23;
    localparam logic [31:0] SISR_ADDR = 32'h0000_0100;

    // Causes 16 and 17 ignore the status-register mask.
    localparam logic [31:0] NMI_MASK  = 32'h0003_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Combinational cause evaluation. Applies the per-cause mask
//            (bits 16/17 always enabled), reports the surviving causes,
//            the index of the highest-priority one (bit 0 highest) and
//            whether any cause survives.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import isr_pkg::*;
#(
    parameter int NCAUSE = 23
) (
    input  logic [NCAUSE-1:0] pend,
    input  logic [NCAUSE-1:0] mask,
    output logic [NCAUSE-1:0] mca,
    output logic [4:0]        il,
    output logic              jisr
);

    assign mca  = pend & (mask | NMI_MASK[NCAUSE-1:0]);
    assign jisr = |mca;

    // Priority encode: scan downwards so the lowest set index wins.
    always_comb begin
        il = 5'd0;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (mca[i]) begin
                il = 5'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/isr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : isr_sequencer
// Purpose  : Interrupt entry/return sequencing between the commit stage and
//            the fetch PC mux. Owns sr/esr/epc/eca, takes interrupts only at
//            instruction boundaries and redirects fetch to the ISR or epc.
// Config   : ISR_SEQ_STICKY_EN - when defined, events are latched in a
//            pending register until taken; otherwise int_req feeds the
//            controller directly and untaken causes are lost.
// Revision : 1.0 - initial release
// ============================================================================
module isr_sequencer #(
    parameter logic [31:0] SISR_ADDR = isr_pkg::SISR_ADDR,
    parameter int          NCAUSE    = isr_pkg::NCAUSE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCAUSE-1:0] int_req,
    input  logic              instr_done,
    input  logic [31:0]       pc_next,
    input  logic              eret,
    input  logic              sr_we,
    input  logic [31:0]       sr_wdata,
    output logic [31:0]       sr,
    output logic [31:0]       esr,
    output logic [31:0]       epc,
    output logic [NCAUSE-1:0] eca,
    output logic              jisr,
    output logic [4:0]        il,
    output logic              pc_load,
    output logic [31:0]       pc_target,
    output logic              busy
);
    import isr_pkg::*;

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [NCAUSE-1:0] w_cause;
    logic [NCAUSE-1:0] w_mca;
    logic              w_raw_jisr;
    logic [31:0]       r_sr;
    logic [31:0]       r_esr;
    logic [31:0]       r_epc;
    logic [NCAUSE-1:0] r_eca;
    logic              w_idle;

`ifdef ISR_SEQ_STICKY_EN
    logic [NCAUSE-1:0] r_pend;
    logic [NCAUSE-1:0] w_clr;

    // Only the cause actually being serviced is retired from pending.
    assign w_clr = jisr ? (NCAUSE'(1) << il) : '0;

    // Accumulate event strobes; they stay until serviced.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend | int_req) & ~w_clr;
        end
    end

    assign w_cause = r_pend;
`else
    assign w_cause = int_req;
`endif

    interrupt_controller #(
        .NCAUSE (NCAUSE)
    ) u_interrupt_controller (
        .pend (w_cause),
        .mask (r_sr[NCAUSE-1:0]),
        .mca  (w_mca),
        .il   (il),
        .jisr (w_raw_jisr)
    );

    assign w_idle = (r_state == IDLE);
    assign jisr   = w_raw_jisr & instr_done & w_idle;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and redirect outputs; interrupt entry outranks eret.
    always_comb begin
        w_state_next = IDLE;
        pc_load      = 1'b0;
        pc_target    = 32'd0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (jisr) begin
                    w_state_next = ENTER;
                end else if (instr_done && eret) begin
                    w_state_next = RETURN;
                end
            end
            ENTER: begin
                pc_load   = 1'b1;
                pc_target = SISR_ADDR;
                busy      = 1'b1;
            end
            RETURN: begin
                pc_load   = 1'b1;
                pc_target = r_epc;
                busy      = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Status and save registers; commit-side writes are ignored while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr  <= '0;
            r_esr <= '0;
            r_epc <= '0;
            r_eca <= '0;
        end else if (jisr) begin
            // An eret cut short by the interrupt keeps the outer save state.
            if (!eret) begin
                r_epc <= pc_next;
                r_esr <= sr_we ? sr_wdata : r_sr;
            end
            r_eca <= w_mca;
            r_sr  <= '0;
        end else if (w_idle && instr_done && eret) begin
            r_sr <= r_esr;
        end else if (w_idle && instr_done && sr_we) begin
            r_sr <= sr_wdata;
        end
    end

    assign sr  = r_sr;
    assign esr = r_esr;
    assign epc = r_epc;
    assign eca = r_eca;

endmodule
`default_nettype wire

// File: tb/tb_isr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_isr_sequencer
// Purpose  : Self-checking bench for isr_sequencer: directed scenarios with
//            literal expectations plus randomized traffic compared every
//            cycle against a behavioural model of entry/return rules.
// Config   : ISR_SEQ_STICKY_EN selects the pending-register expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isr_sequencer;

    localparam int             NC   = 23;
    localparam logic [31:0]    SISR = 32'h0000_0100;
    localparam logic [NC-1:0]  NMI  = 23'h03_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     int_req = '0;
    logic              instr_done = 1'b0;
    logic [31:0]       pc_next = 32'd0;
    logic              eret = 1'b0;
    logic              sr_we = 1'b0;
    logic [31:0]       sr_wdata = 32'd0;
    logic [31:0]       sr, esr, epc, pc_target;
    logic [NC-1:0]     eca;
    logic              jisr, pc_load, busy;
    logic [4:0]        il;

    always #5 clk = ~clk;

    isr_sequencer #(
        .SISR_ADDR (SISR),
        .NCAUSE    (NC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .int_req    (int_req),
        .instr_done (instr_done),
        .pc_next    (pc_next),
        .eret       (eret),
        .sr_we      (sr_we),
        .sr_wdata   (sr_wdata),
        .sr         (sr),
        .esr        (esr),
        .epc        (epc),
        .eca        (eca),
        .jisr       (jisr),
        .il         (il),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]   m_sr, m_esr, m_epc, m_redir_addr;
    logic [NC-1:0] m_eca, m_pend, m_src, m_act;
    bit            m_redir;
    bit            m_take;
    int            m_top;
    bit            checking = 1'b0;

    always @(negedge clk) begin
`ifdef ISR_SEQ_STICKY_EN
        m_src = m_pend;
`else
        m_src = int_req;
`endif
        m_act = m_src & (m_sr[NC-1:0] | NMI);
        m_top = -1;
        for (int j = 0; j < NC; j++) begin
            if (m_act[j]) begin
                m_top = j;
                break;
            end
        end
        m_take = !m_redir && instr_done && (m_act != '0);

        if (checking) begin
            chk("m_jisr", {31'd0, jisr}, {31'd0, m_take});
            if (m_take) chk("m_il", {27'd0, il}, m_top);
            chk("m_pc_load", {31'd0, pc_load}, {31'd0, m_redir});
            chk("m_busy", {31'd0, busy}, {31'd0, m_redir});
            chk("m_pc_target", pc_target, m_redir ? m_redir_addr : 32'd0);
            chk("m_sr", sr, m_sr);
            chk("m_esr", esr, m_esr);
            chk("m_epc", epc, m_epc);
            chk("m_eca", {9'd0, eca}, {9'd0, m_eca});
        end

        if (reset) begin
            m_sr = 0; m_esr = 0; m_epc = 0; m_eca = '0; m_pend = '0;
            m_redir = 0; m_redir_addr = 0;
        end else begin
            m_pend = m_pend | int_req;
            if (m_take) m_pend[m_top] = 1'b0;
            if (m_redir) begin
                m_redir = 0;
            end else if (m_take) begin
                if (!eret) begin
                    m_epc = pc_next;
                    m_esr = sr_we ? sr_wdata : m_sr;
                end
                m_eca = m_act;
                m_sr = 0;
                m_redir = 1; m_redir_addr = SISR;
            end else if (instr_done && eret) begin
                m_sr = m_esr;
                m_redir = 1; m_redir_addr = m_epc;
            end else if (instr_done && sr_we) begin
                m_sr = sr_wdata;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        int_req = '0; instr_done = 0; eret = 0; sr_we = 0; sr_wdata = 0; pc_next = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        checking = 1;

        // Reset state
        chk("rst_sr", sr, 32'd0);
        chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rst_pc_target", pc_target, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_eca", {9'd0, eca}, 32'd0);
        chk("rst_epc", epc, 32'd0);

        // Non-maskable causes 16 and 17 with sr=0
        int_req = NMI;
        tick();
        instr_done = 1; pc_next = 32'h40;
        @(negedge clk);
        chk("nmi_jisr", {31'd0, jisr}, 32'd1);
        chk("nmi_il", {27'd0, il}, 32'd16);
        tick(); idle_inputs();
        chk("nmi_epc", epc, 32'h40);
        chk("nmi_sr", sr, 32'd0);
        chk("nmi_pc_load", {31'd0, pc_load}, 32'd1);
        chk("nmi_pc_target", pc_target, 32'h100);
        chk("nmi_eca", {9'd0, eca}, 32'h0003_0000);
        tick();
        chk("nmi_idle", {31'd0, busy}, 32'd0);
        instr_done = 1;
        @(negedge clk);
`ifdef ISR_SEQ_STICKY_EN
        chk("nmi17_jisr", {31'd0, jisr}, 32'd1);
        chk("nmi17_il", {27'd0, il}, 32'd17);
`else
        chk("nmi17_lost", {31'd0, jisr}, 32'd0);
`endif
        tick(); idle_inputs(); tick();

        // Priority: bits 0 and 1 with everything enabled
        sr_we = 1; sr_wdata = 32'hFFFF_FFFF; instr_done = 1;
        tick(); idle_inputs();
        chk("pri_sr", sr, 32'hFFFF_FFFF);
        int_req = 23'h3;
        tick();
        instr_done = 1; pc_next = 32'h200;
        @(negedge clk);
        chk("pri_jisr", {31'd0, jisr}, 32'd1);
        chk("pri_il", {27'd0, il}, 32'd0);
        tick(); idle_inputs();
        chk("pri_eca", {9'd0, eca}, 32'h3);
        chk("pri_esr", esr, 32'hFFFF_FFFF);
        chk("pri_epc", epc, 32'h200);
        instr_done = 1; eret = 1;   // ignored while busy
        @(negedge clk);
        chk("busy_jisr", {31'd0, jisr}, 32'd0);
        tick(); idle_inputs();
        chk("busy_ign_sr", sr, 32'd0);
        chk("busy_ign_load", {31'd0, pc_load}, 32'd0);

        // Return path
        instr_done = 1; eret = 1;
        tick(); idle_inputs();
        chk("ret_sr", sr, 32'hFFFF_FFFF);
        chk("ret_pc_load", {31'd0, pc_load}, 32'd1);
        chk("ret_pc_target", pc_target, 32'h200);
        tick();
        chk("ret_idle", {31'd0, busy}, 32'd0);

        // Simultaneous eret and interrupt
        int_req = 23'h4;
        tick();
        instr_done = 1; eret = 1; pc_next = 32'h300;
        @(negedge clk);
        chk("sim_jisr", {31'd0, jisr}, 32'd1);
`ifdef ISR_SEQ_STICKY_EN
        chk("sim_il", {27'd0, il}, 32'd1);
`else
        chk("sim_il", {27'd0, il}, 32'd2);
`endif
        tick(); idle_inputs();
        chk("sim_epc", epc, 32'h200);
        chk("sim_esr", esr, 32'hFFFF_FFFF);
        chk("sim_target", pc_target, 32'h100);
        tick();

        // Reset during ENTER
        int_req = 23'h1_0000;
        tick();
        instr_done = 1; pc_next = 32'h44;
        @(negedge clk);
        chk("rste_jisr", {31'd0, jisr}, 32'd1);
        tick(); idle_inputs();
        chk("rste_enter", {31'd0, pc_load}, 32'd1);
        reset = 1;
        tick();
        reset = 0;
        chk("rste_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rste_busy", {31'd0, busy}, 32'd0);
        chk("rste_target", pc_target, 32'd0);
        chk("rste_epc", epc, 32'd0);
        chk("rste_eca", {9'd0, eca}, 32'd0);

        // Masked cause 7
        int_req = 23'h80; instr_done = 1;
        @(negedge clk);
        chk("msk_jisr0", {31'd0, jisr}, 32'd0);
        tick(); idle_inputs();
        instr_done = 1;
        @(negedge clk);
        chk("msk_jisr1", {31'd0, jisr}, 32'd0);
        tick(); idle_inputs();
        sr_we = 1; sr_wdata = 32'h80; instr_done = 1;
        tick(); idle_inputs();
        instr_done = 1; pc_next = 32'h500;
        @(negedge clk);
`ifdef ISR_SEQ_STICKY_EN
        chk("msk_take", {31'd0, jisr}, 32'd1);
        chk("msk_il", {27'd0, il}, 32'd7);
        tick(); idle_inputs();
        chk("msk_eca", {9'd0, eca}, 32'h80);
`else
        chk("msk_lost", {31'd0, jisr}, 32'd0);
        tick(); idle_inputs();
`endif
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            int_req    = '0;
            if ($urandom_range(0, 2) == 0) int_req = NC'(1) << $urandom_range(0, NC - 1);
            if ($urandom_range(0, 9) == 0) int_req = int_req | (NC'(1) << $urandom_range(0, NC - 1));
            instr_done = ($urandom_range(0, 1) == 1);
            eret       = ($urandom_range(0, 7) == 0);
            sr_we      = ($urandom_range(0, 5) == 0);
            sr_wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            pc_next    = 32'($urandom) & 32'hFFFF_FFFC;
            tick();
        end
        reset = 0;
        idle_inputs();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
